fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the single-cycle datapath.
- Issues word reads to instruction memory over a req/gnt/rvalid handshake and buffers the returned words with their PCs in a small prefetch FIFO.
- Presents one instruction per cycle to the datapath (instr/instr_pc/instr_valid) and honours a stall from it.
- Handles taken-branch redirects (the datapath's PCSrc with its Result value) by flushing the FIFO and discarding stale in-flight reads.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, PC step, FIFO entry.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, instr}, flush has priority over push/pop,
// head is read from registered storage and forced to zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [31:0]                push_pc,
    input  logic [31:0]                push_instr,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic [31:0]                head_pc,
    output logic [31:0]                head_instr
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer and occupancy bookkeeping; a flush empties the FIFO in one cycle.
    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage write port.
    // NOTE: storage has no reset; validity lives in count, and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
    end

    assign head       = empty ? '0 : mem[rd_ptr];
    assign head_pc    = head.pc;
    assign head_instr = head.instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read at a time, credit-limited
// prefetch into fetch_fifo, redirect flushes the FIFO and drops stale responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int AW = $clog2(DEPTH);

    state_t        state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [31:0]   pend_pc, pend_pc_n;
    logic          pend_valid, pend_valid_n;
    logic [31:0]   target_pc;
    logic [AW:0]   count;
    logic [AW+1:0] used;
    logic          empty, full, credit, push, pop;

    assign target_pc = redirect_pc & ~32'h3;

    // A response still owed to us in WAIT reserves a slot; count is registered,
    // so a pop in this cycle only frees credit next cycle.
    assign used   = {1'b0, count} + (AW+2)'(state == WAIT);
    assign credit = !full && (used < (AW+2)'(DEPTH));

    assign imem_addr   = fetch_pc;
    assign instr_valid = !empty;
    assign pop         = instr_valid && !stall && !redirect;

    // FSM state, fetch address and the redirect captured while a request waits for grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            pend_valid <= pend_valid_n;
            pend_pc    <= pend_pc_n;
        end
    end

    // Next-state, request and push decode.
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        pend_valid_n = pend_valid;
        pend_pc_n    = pend_pc;
        imem_req     = 1'b0;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (redirect)    fetch_pc_n = target_pc;
                else if (credit) state_n    = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    pend_valid_n = 1'b0;
                    if (redirect) begin
                        fetch_pc_n = target_pc;
                        state_n    = DROP;
                    end else if (pend_valid) begin
                        fetch_pc_n = pend_pc;
                        state_n    = DROP;
                    end else begin
                        fetch_pc_n = fetch_pc + PC_INC;
                        state_n    = WAIT;
                    end
                end else if (redirect) begin
                    // Address must stay stable until granted; remember where to go.
                    pend_valid_n = 1'b1;
                    pend_pc_n    = target_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_n = target_pc;
                    state_n    = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
            end
            DROP: begin
                if (redirect)    fetch_pc_n = target_pc;
                if (imem_rvalid) state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_pc    (fetch_pc - PC_INC),
        .push_instr (imem_rdata),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .head_pc    (instr_pc),
        .head_instr (instr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory, expected grant addresses
// and expected {pc, instr} pushed by the stimulus, compared by a negedge monitor.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b1;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory: grants when enabled, answers lat cycles after the grant.
    logic        gnt_en = 1'b1;
    int          lat = 1;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;

    assign imem_gnt    = imem_req && gnt_en;
    assign imem_rvalid = m_busy && (m_cnt == 0);
    assign imem_rdata  = imem_rvalid ? data_of(m_addr) : 32'h0;

    always @(posedge clk) begin
        if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
        if (imem_req && imem_gnt) begin
            m_busy <= 1'b1;
            m_cnt  <= lat - 1;
            m_addr <= imem_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard queues: expected grant addresses and expected popped PCs.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    int          n_pops = 0;
    int          n_grants = 0;

    task automatic expect_from(input logic [31:0] base, input int n);
        exp_addr_q.delete();
        exp_pc_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(base + 32'(4 * i));
            exp_pc_q.push_back(base + 32'(4 * i));
        end
    endtask

    // Monitor: grants, pops and address stability while a request waits.
    logic        hold_v = 1'b0;
    logic [31:0] hold_addr = '0;
    initial begin
        logic [31:0] p;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (hold_v) begin
                    check("req_held", 32'(imem_req), 32'd1);
                    check("addr_held", imem_addr, hold_addr);
                end
                hold_v    = imem_req && !imem_gnt;
                hold_addr = imem_addr;
                if (imem_req && imem_gnt) begin
                    n_grants++;
                    if (exp_addr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL grant_unexpected: got addr %h, required no grant", imem_addr);
                    end else begin
                        p = exp_addr_q.pop_front();
                        check("imem_addr", imem_addr, p);
                    end
                end
                if (instr_valid && !stall && !redirect) begin
                    n_pops++;
                    if (exp_pc_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL pop_unexpected: got pc %h, required no instruction", instr_pc);
                    end else begin
                        p = exp_pc_q.pop_front();
                        check("instr_pc", instr_pc, p);
                        check("instr", instr, data_of(p));
                    end
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = imem_req && imem_gnt;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL wait_grant: got no grant in 60 cycles, required one");
        end
    endtask

    task automatic wait_pops(input int k);
        int n0 = n_pops;
        for (int i = 0; i < 300 && n_pops < n0 + k; i++) @(negedge clk);
        if (n_pops < n0 + k) begin
            total++; bad++;
            $display("FAIL wait_pops: got %0d pops, required %0d", n_pops - n0, k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        bit          got;

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // Release with stall held: first instruction 3 cycles after leaving IDLE, then fill to DEPTH.
        expect_from(32'h0, 40);
        reset = 1'b1;
        @(negedge clk);
        check("lat_c1_valid", 32'(instr_valid), 32'd0);
        check("lat_c1_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        check("lat_c2_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("lat_c3_valid", 32'(instr_valid), 32'd1);
        repeat (17) @(negedge clk);
        check("full_grants", 32'(n_grants), 32'd4);
        check("full_req", 32'(imem_req), 32'd0);
        check("full_valid", 32'(instr_valid), 32'd1);

        // Drain 0,4,8,12 back to back, then keep streaming.
        step();
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_no_gap", 32'(instr_valid), 32'd1);
        end
        wait_pops(3);

        // Redirect while WAIT, response 3 cycles after grant is stale.
        step();
        lat = 3;
        wait_grant();
        step();
        redirect = 1'b1; redirect_pc = 32'h100; expect_from(32'h100, 40);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("wait_redir_valid", 32'(instr_valid), 32'd0);
        wait_pops(2);

        // Redirect while REQ is not granted; old address held for two more cycles.
        step();
        lat = 1; gnt_en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = imem_req;
        end
        check("req_seen", 32'(got), 32'd1);
        old = (exp_addr_q.size() != 0) ? exp_addr_q[0] : 32'h0;
        step();
        redirect = 1'b1; redirect_pc = 32'h200; expect_from(32'h200, 40);
        exp_addr_q.push_front(old);
        step();
        redirect = 1'b0;
        step();
        step();
        gnt_en = 1'b1;
        wait_pops(2);

        // Redirect in the same cycle as rvalid and an otherwise legal pop; low bits ignored.
        step();
        stall = 1'b1;
        wait_grant();
        wait_grant();
        step();
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h303; expect_from(32'h300, 40);
        @(negedge clk);
        check("same_cyc_rvalid", 32'(imem_rvalid), 32'd1);
        check("same_cyc_valid", 32'(instr_valid), 32'd1);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("same_cyc_flush", 32'(instr_valid), 32'd0);
        wait_pops(2);

        // PC wrap from 32'hFFFF_FFFC to 0.
        wait_grant();
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; expect_from(32'hFFFF_FFFC, 40);
        step();
        redirect = 1'b0;
        wait_pops(3);

        // Async reset in WAIT with entries buffered; the late response lands during reset.
        step();
        stall = 1'b1; lat = 3;
        wait_grant();
        wait_grant();
        @(posedge clk);
        #2;
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        reset = 1'b0;
        expect_from(32'h0, 40);
        #1;
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_instr", instr, 32'h0);
        check("async_instr_pc", instr_pc, 32'h0);
        check("async_req", 32'(imem_req), 32'd0);
        check("async_addr", imem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("late_rvalid_seen", 32'(imem_rvalid), 32'd1);
        lat = 1; stall = 1'b0;
        reset = 1'b1;
        wait_pops(2);

        step();
        stall = 1'b1;
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
